// File: rtl/fakeram_ctrl_pkg.sv
// Shared types and defaults for the fake SRAM request controller.
// The request and data types are sized for the default 256x95 macro.
package fakeram_ctrl_pkg;

  localparam int unsigned FakeramWidth     = 95;
  localparam int unsigned FakeramEls       = 256;
  localparam int unsigned FakeramAddrWidth = 8;

  typedef logic [FakeramWidth-1:0] fakeram_data_t;

  typedef struct packed {
    logic                        w;
    logic [FakeramAddrWidth-1:0] addr;
    fakeram_data_t               data;
    fakeram_data_t               w_mask;
  } fakeram_req_s;

  // A read may issue only if every outstanding read (buffered or in flight) still has a slot.
  function automatic logic has_read_credit(input int unsigned count, input logic pending,
                                           input int unsigned els);
    return (count + {31'b0, pending}) < els;
  endfunction

endpackage

// File: rtl/fakeram_resp_fifo.sv
// Register-based 1r1w response FIFO with occupancy count and valid/yumi dequeue.
module fakeram_resp_fifo #(
  parameter int unsigned width_p = 95,
  parameter int unsigned els_p   = 3,
  localparam int unsigned PtrWidth   = $clog2(els_p),
  localparam int unsigned CountWidth = $clog2(els_p + 1)
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  enq_i,
  input  logic [width_p-1:0]    data_i,
  output logic                  v_o,
  output logic [width_p-1:0]    data_o,
  input  logic                  yumi_i,
  output logic [CountWidth-1:0] count_o
);

  logic [width_p-1:0]    mem_q [els_p];
  logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CountWidth-1:0] count_q, count_d;
  logic                  deq;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    deq      = yumi_i & (count_q != '0);
    rd_ptr_d = deq ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = enq_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    count_d  = count_q;
    unique case ({enq_i, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; when full with a dequeue, wr_ptr equals the slot being vacated.
  always_ff @(posedge clk_i) begin
    if (reset_n_i && enq_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign v_o     = reset_n_i & (count_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o)
    else $error("yumi_i asserted while v_o is low");

  no_overflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (enq_i && !deq) |-> (count_q != CountWidth'(els_p)))
    else $error("response FIFO overflow");

endmodule

// File: rtl/fakeram_req_ctrl.sv
// Ready/valid front-end for the single-port fake SRAM: drives macro pins on acceptance and
// buffers 1-cycle read data in a credit-managed response FIFO.
module fakeram_req_ctrl
  import fakeram_ctrl_pkg::*;
#(
  parameter int unsigned width_p      = FakeramWidth,
  parameter int unsigned els_p        = FakeramEls,
  parameter int unsigned addr_width_p = FakeramAddrWidth,
  parameter int unsigned resp_els_p   = 3
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    v_i,
  input  logic                    w_i,
  input  logic [addr_width_p-1:0] addr_i,
  input  logic [width_p-1:0]      data_i,
  input  logic [width_p-1:0]      w_mask_i,
  output logic                    ready_o,
  output logic                    v_o,
  output logic [width_p-1:0]      data_o,
  input  logic                    yumi_i,
  output logic                    sram_ce_o,
  output logic                    sram_we_o,
  output logic [addr_width_p-1:0] sram_addr_o,
  output logic [width_p-1:0]      sram_wd_o,
  output logic [width_p-1:0]      sram_w_mask_o,
  input  logic [width_p-1:0]      sram_rd_i
);

  localparam int unsigned CountWidth = $clog2(resp_els_p + 1);

  if (resp_els_p < 2) begin : gen_depth_check
    $error("resp_els_p must be at least 2");
  end
  if (addr_width_p != $clog2(els_p)) begin : gen_addr_check
    $error("addr_width_p must equal clog2(els_p)");
  end

  logic [CountWidth-1:0] fifo_count;
  logic                  rd_pending_q, rd_pending_d;
  logic                  acc;
  logic                  acc_w;

  // Pins are zeroed when idle so the macro never sees stale or unknown address/data.
  always_comb begin
    ready_o       = reset_n_i & (w_i | has_read_credit(32'(fifo_count), rd_pending_q,
                                                       resp_els_p));
    acc           = v_i & ready_o;
    acc_w         = acc & w_i;
    sram_ce_o     = acc;
    sram_we_o     = acc_w;
    sram_addr_o   = acc ? addr_i : '0;
    sram_wd_o     = acc_w ? data_i : '0;
    sram_w_mask_o = acc_w ? w_mask_i : '0;
    rd_pending_d  = acc & ~w_i;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rd_pending_q <= 1'b0;
    end else begin
      rd_pending_q <= rd_pending_d;
    end
  end

  fakeram_resp_fifo #(
    .width_p (width_p),
    .els_p   (resp_els_p)
  ) u_resp_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .enq_i     (rd_pending_q),
    .data_i    (sram_rd_i),
    .v_o       (v_o),
    .data_o    (data_o),
    .yumi_i    (yumi_i),
    .count_o   (fifo_count)
  );

endmodule
